gate_exerciser: RTL



---
 rtl/gate_exerciser_pkg.sv | 15 +
 rtl/gate_exerciser_if.sv | 47 ++++
 rtl/gate_ref_model.sv | 13 +
 rtl/gate_exerciser.sv | 136 +++++++++++++
 4 files changed

// File: rtl/gate_exerciser_pkg.sv
// gate_exerciser_pkg: shared types and constants for the AND-gate exerciser.
// Optional feature macro used by this slice: GATE_EXERCISER_FAULT_INJECT_EN.
package gate_exerciser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } gx_state_t;

  localparam int unsigned GX_NUM_VECTORS = 4;
  localparam int unsigned GX_IDX_W       = 2;

endpackage

// File: rtl/gate_exerciser_if.sv
// gate_exerciser_if: control, result and gate-drive signals of the exerciser.
// With GATE_EXERCISER_FAULT_INJECT_EN defined the bundle carries fault_inj.
interface gate_exerciser_if
  import gate_exerciser_pkg::*;
#(
  parameter int unsigned ERR_W = 8
);

  logic                start;
  logic                dut_out;
  logic                drive_in0;
  logic                drive_in1;
  logic                busy;
  logic                done;
  logic                pass;
  logic [ERR_W-1:0]    err_count;
  logic [GX_IDX_W-1:0] first_fail_idx;
  logic                fail_seen;
`ifdef GATE_EXERCISER_FAULT_INJECT_EN
  logic                fault_inj;

  // Exerciser side
  modport master (
    input  start, dut_out, fault_inj,
    output drive_in0, drive_in1, busy, done, pass, err_count, first_fail_idx, fail_seen
  );

  // Controller / gate side
  modport slave (
    output start, dut_out, fault_inj,
    input  drive_in0, drive_in1, busy, done, pass, err_count, first_fail_idx, fail_seen
  );
`else
  // Exerciser side
  modport master (
    input  start, dut_out,
    output drive_in0, drive_in1, busy, done, pass, err_count, first_fail_idx, fail_seen
  );

  // Controller / gate side
  modport slave (
    output start, dut_out,
    input  drive_in0, drive_in1, busy, done, pass, err_count, first_fail_idx, fail_seen
  );
`endif

endinterface

// File: rtl/gate_ref_model.sv
// gate_ref_model: golden function of the gate under test (2-input AND),
// with an optional inversion used for checker self-test.
module gate_ref_model (
  input  logic in0,
  input  logic in1,
  input  logic invert,
  output logic expected_c
);

  // Golden response; swap this expression to exercise other gate types
  assign expected_c = (in0 & in1) ^ invert;

endmodule

// File: rtl/gate_exerciser.sv
// gate_exerciser: sweeps all 2-input vectors over a gate PASSES times,
// counts mismatches against gate_ref_model and reports the result.
// Optional feature macro: GATE_EXERCISER_FAULT_INJECT_EN (fault_inj input).
module gate_exerciser
  import gate_exerciser_pkg::*;
#(
  parameter int unsigned PASSES = 4,
  parameter int unsigned ERR_W  = 8
) (
  input logic              clk,
  input logic              rst,
  gate_exerciser_if.master gx
);

  localparam int unsigned       PC_W      = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [PC_W-1:0]   PCNT_LAST = PC_W'(PASSES - 1);
  localparam logic [GX_IDX_W-1:0] IDX_LAST = GX_IDX_W'(GX_NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  gx_state_t           state_q, state_n;
  logic [GX_IDX_W-1:0] idx_q, idx_n;
  logic [PC_W-1:0]     pcnt_q, pcnt_n;
  logic [ERR_W-1:0]    err_q, err_n;
  logic [GX_IDX_W-1:0] ffi_q, ffi_n;
  logic                fs_q, fs_n;
  logic                pass_q, pass_n;
  logic                busy_q, busy_n;
  logic                done_q, done_n;
  logic                drv0_q, drv0_n;
  logic                drv1_q, drv1_n;
  logic                inv_c;
  logic                expected_c;
  logic                mismatch_c;

  // Self-test inversion of the expected value on the last vector
`ifdef GATE_EXERCISER_FAULT_INJECT_EN
  assign inv_c = gx.fault_inj & (idx_q == IDX_LAST);
`else
  assign inv_c = 1'b0;
`endif

  gate_ref_model u_ref (
    .in0        (idx_q[0]),
    .in1        (idx_q[1]),
    .invert     (inv_c),
    .expected_c (expected_c)
  );

  assign mismatch_c = (gx.dut_out != expected_c);

  // Next-state and next-output computation
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    pcnt_n  = pcnt_q;
    err_n   = err_q;
    ffi_n   = ffi_q;
    fs_n    = fs_q;
    pass_n  = pass_q;
    unique case (state_q)
      IDLE: begin
        if (gx.start) begin
          state_n = DRIVE;
          idx_n   = '0;
          pcnt_n  = '0;
          err_n   = '0;
          ffi_n   = '0;
          fs_n    = 1'b0;
          pass_n  = 1'b0;
        end
      end
      DRIVE: state_n = SAMPLE;
      SAMPLE: begin
        if (mismatch_c) begin
          if (err_q != ERR_MAX) err_n = err_q + ERR_W'(1);
          if (!fs_q) begin
            fs_n  = 1'b1;
            ffi_n = idx_q;
          end
        end
        idx_n   = idx_q + GX_IDX_W'(1);
        state_n = DRIVE;
        if (idx_q == IDX_LAST) begin
          if (pcnt_q == PCNT_LAST) state_n = DONE;
          else pcnt_n = pcnt_q + PC_W'(1);
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == DRIVE) || (state_n == SAMPLE);
    done_n = (state_n == DONE);
    if (state_n == DONE) pass_n = (err_n == '0) && !fs_n;
    drv0_n = busy_n & idx_n[0];
    drv1_n = busy_n & idx_n[1];
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pcnt_q  <= '0;
      err_q   <= '0;
      ffi_q   <= '0;
      fs_q    <= 1'b0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drv0_q  <= 1'b0;
      drv1_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      pcnt_q  <= pcnt_n;
      err_q   <= err_n;
      ffi_q   <= ffi_n;
      fs_q    <= fs_n;
      pass_q  <= pass_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      drv0_q  <= drv0_n;
      drv1_q  <= drv1_n;
    end
  end

  assign gx.drive_in0      = drv0_q;
  assign gx.drive_in1      = drv1_q;
  assign gx.busy           = busy_q;
  assign gx.done           = done_q;
  assign gx.pass           = pass_q;
  assign gx.err_count      = err_q;
  assign gx.first_fail_idx = ffi_q;
  assign gx.fail_seen      = fs_q;

endmodule
